// File: rtl/legv8_inst_encoder.sv
// legv8_inst_encoder: packs symbolic LEGv8 instructions into 32-bit words and writes them to imem from address 0.
// Latency: one cycle from an accepted transfer to the registered imem write strobe; back-to-back writes, no bubbles.
// Backpressure: in_ready drops when full, outside LOAD, or during start/finish; optional ENC_RANGE_CHECK_EN rejects LDUR/STUR with out-of-range imm.
module legv8_inst_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  localparam logic [2:0] K_LDUR = 3'd0;
  localparam logic [2:0] K_STUR = 3'd1;
  localparam logic [2:0] K_CBZ  = 3'd2;
  localparam logic [2:0] K_ADD  = 3'd3;
  localparam logic [2:0] K_SUB  = 3'd4;
  localparam logic [2:0] K_AND  = 3'd5;
  localparam logic [2:0] K_ORR  = 3'd6;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;

  logic [31:0]         enc_word;
  logic                bad_kind;
  logic                reject;
  logic                xfer;

  // count only reaches 2**ADDR_W when every address has been written, so its MSB is the full flag
  assign full      = count_q[ADDR_W];
  assign count     = count_q;
  assign imem_we   = we_q;
  assign imem_addr = addr_q;
  assign imem_wdata = wdata_q;
  assign err       = err_q;
  assign done      = (state_q == S_DONE);
  assign in_ready  = (state_q == S_LOAD) && !full && !start && !finish;
  assign xfer      = in_valid && in_ready;

  // Bit-field packing of the symbolic instruction; unused fields of each format are ignored
  always_comb begin
    enc_word = '0;
    bad_kind = 1'b0;
    case (in_kind)
      K_LDUR:  enc_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
      K_STUR:  enc_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
      K_CBZ:   enc_word = {8'b10110100, in_imm, in_rt};
      K_ADD:   enc_word = {11'b10001011000, in_rm, 6'b000000, in_rn, in_rt};
      K_SUB:   enc_word = {11'b11001011000, in_rm, 6'b000000, in_rn, in_rt};
      K_AND:   enc_word = {11'b10001010000, in_rm, 6'b000000, in_rn, in_rt};
      K_ORR:   enc_word = {11'b10101010000, in_rm, 6'b000000, in_rn, in_rt};
      default: bad_kind = 1'b1;
    endcase
  end

  // Rejection: illegal kind always; with range checking, a D-format imm that does not fit in 9 signed bits
`ifdef ENC_RANGE_CHECK_EN
  logic is_mem;
  logic imm_oob;
  assign is_mem  = (in_kind == K_LDUR) || (in_kind == K_STUR);
  assign imm_oob = (in_imm[18:9] != {10{in_imm[8]}});
  assign reject  = bad_kind || (is_mem && imm_oob);
`else
  assign reject  = bad_kind;
`endif

  // Session control and write-port next state; start always wins over finish and transfers
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (start) begin
          count_d = '0;
        end else if (finish) begin
          state_d = S_DONE;
        end else if (xfer) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            we_d    = 1'b1;
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc_word;
            count_d = count_q + (ADDR_W+1)'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; synchronous reset drops any pending write
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

endmodule
